conv_tile_sched: RTL and testbench

- Tile-level scheduler for the 8x2 convolution PE array (Tm=8 output maps x Tn=2 input maps per pass).
- Walks output-channel tiles m (step TM) in the outer loop and input-channel tiles n (step TN) in the inner loop.
- Per tile: requests the buffer loader, then pulses the conv engine's enable, then waits for its done plus pipeline drain.
- After the last n tile of each m tile, requests the output store. Sits between the host/DMA control and the conv engine.

---
 rtl/conv_tile_sched.sv | 174 +++++++++++++++++
 tb/tb_conv_tile_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_sched.sv
// Tile-level scheduler for the 8x2 convolution PE array: walks output-channel
// tiles (outer) and input-channel tiles (inner), sequencing load, conv, drain and store.
module conv_tile_sched #(
  parameter int N     = 3,
  parameter int M     = 16,
  parameter int TN    = 2,
  parameter int TM    = 8,
  parameter int CH_W  = 8,
  parameter int DRAIN = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            ld_req,
  output logic [CH_W-1:0] ld_n,
  output logic [CH_W-1:0] ld_m,
  output logic            ld_bias,
  input  logic            ld_ack,
  output logic            conv_enable,
  output logic [CH_W-1:0] conv_n,
  input  logic            conv_done,
  output logic            st_req,
  output logic [CH_W-1:0] st_m,
  input  logic            st_ack
);

  // One guard bit so n+TN and m+TM can never wrap before the compare.
  localparam int IW = CH_W + 1;
  localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

  localparam logic [IW-1:0] N_I  = IW'(N);
  localparam logic [IW-1:0] M_I  = IW'(M);
  localparam logic [IW-1:0] TN_I = IW'(TN);
  localparam logic [IW-1:0] TM_I = IW'(TM);
  localparam logic [CW-1:0] CNT_INIT = CW'((DRAIN > 0) ? DRAIN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_WAIT,
    S_DRAIN,
    S_STORE,
    S_FIN
  } state_t;

  state_t        state;
  logic [IW-1:0] n;
  logic [IW-1:0] m;
  logic [CW-1:0] cnt;

  logic [IW-1:0] n_next;
  logic [IW-1:0] m_next;
  logic          more_n;
  logic          more_m;
  logic          drain_exit;

  assign n_next = n + TN_I;
  assign m_next = m + TM_I;
  assign more_n = (n_next < N_I);
  assign more_m = (m_next < M_I);

  // With DRAIN=0 the WAIT state takes the drain exit decision itself.
  assign drain_exit = ((state == S_WAIT) && conv_done && (DRAIN == 0)) ||
                      ((state == S_DRAIN) && (cnt == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      n           <= '0;
      m           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ld_req      <= 1'b0;
      ld_n        <= '0;
      ld_m        <= '0;
      ld_bias     <= 1'b0;
      conv_enable <= 1'b0;
      conv_n      <= '0;
      st_req      <= 1'b0;
      st_m        <= '0;
    end else begin
      done        <= 1'b0;
      conv_enable <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            n       <= '0;
            m       <= '0;
            busy    <= 1'b1;
            ld_req  <= 1'b1;
            ld_n    <= '0;
            ld_m    <= '0;
            ld_bias <= 1'b1;
            state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (ld_ack) begin
            ld_req  <= 1'b0;
            ld_bias <= 1'b0;
            state   <= S_CONV;
          end
        end

        S_CONV: begin
          conv_enable <= 1'b1;
          conv_n      <= n[CH_W-1:0];
          state       <= S_WAIT;
        end

        S_WAIT: begin
          if (conv_done && (DRAIN != 0)) begin
            cnt   <= CNT_INIT;
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end

        S_STORE: begin
          if (st_ack) begin
            st_req <= 1'b0;
            if (more_m) begin
              m       <= m_next;
              n       <= '0;
              ld_req  <= 1'b1;
              ld_n    <= '0;
              ld_m    <= m_next[CH_W-1:0];
              ld_bias <= 1'b1;
              state   <= S_LOAD;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      // Shared exit of the drain window: next input tile, or store this output tile.
      if (drain_exit) begin
        if (more_n) begin
          n       <= n_next;
          ld_req  <= 1'b1;
          ld_n    <= n_next[CH_W-1:0];
          ld_m    <= m[CH_W-1:0];
          ld_bias <= 1'b0;
          state   <= S_LOAD;
        end else begin
          st_req <= 1'b1;
          st_m   <= m[CH_W-1:0];
          state  <= S_STORE;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_tile_sched.sv
// Bench for conv_tile_sched: three configurations run against a loop-nest model
// of the expected load/conv/store sequence with handshake responders.
module tb_conv_tile_sched;

  localparam int NI = 3;
  localparam int DR = 4;

  logic       clk = 1'b0;
  logic       reset_n_s     [NI];
  logic       start_s       [NI];
  logic       busy_s        [NI];
  logic       done_s        [NI];
  logic       ld_req_s      [NI];
  logic [7:0] ld_n_s        [NI];
  logic [7:0] ld_m_s        [NI];
  logic       ld_bias_s     [NI];
  logic       ld_ack_s      [NI];
  logic       conv_enable_s [NI];
  logic [7:0] conv_n_s      [NI];
  logic       conv_done_s   [NI];
  logic       st_req_s      [NI];
  logic [7:0] st_m_s        [NI];
  logic       st_ack_s      [NI];

  int cfg_n [NI] = '{3, 2, 5};
  int cfg_m [NI] = '{16, 8, 9};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Expected sequences produced by the model.
  int e_ld_n [NI][16];
  int e_ld_m [NI][16];
  int e_ld_b [NI][16];
  int e_cv   [NI][16];
  int e_st   [NI][16];
  int n_ld [NI];
  int n_cv [NI];
  int n_st [NI];

  // Monitor and responder state.
  bit active [NI];
  int ack_dly [NI];
  bit noise [NI];
  int p_ld [NI];
  int p_cv [NI];
  int p_st [NI];
  int seen_done [NI];
  bit layer_done [NI];
  int start_cyc [NI];
  int lack_cyc [NI];
  int cd_cyc [NI];
  bit cd_pend [NI];
  int last_conv [NI];
  bit prev_ld [NI];
  bit prev_st [NI];
  bit prev_ce [NI];
  bit prev_ldacc [NI];
  bit prev_stacc [NI];

  conv_tile_sched #(.N(3), .M(16), .TN(2), .TM(8), .CH_W(8), .DRAIN(DR)) u0 (
    .clk(clk), .reset_n(reset_n_s[0]), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .ld_req(ld_req_s[0]), .ld_n(ld_n_s[0]), .ld_m(ld_m_s[0]), .ld_bias(ld_bias_s[0]),
    .ld_ack(ld_ack_s[0]), .conv_enable(conv_enable_s[0]), .conv_n(conv_n_s[0]),
    .conv_done(conv_done_s[0]), .st_req(st_req_s[0]), .st_m(st_m_s[0]), .st_ack(st_ack_s[0]));

  conv_tile_sched #(.N(2), .M(8), .TN(2), .TM(8), .CH_W(8), .DRAIN(DR)) u1 (
    .clk(clk), .reset_n(reset_n_s[1]), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .ld_req(ld_req_s[1]), .ld_n(ld_n_s[1]), .ld_m(ld_m_s[1]), .ld_bias(ld_bias_s[1]),
    .ld_ack(ld_ack_s[1]), .conv_enable(conv_enable_s[1]), .conv_n(conv_n_s[1]),
    .conv_done(conv_done_s[1]), .st_req(st_req_s[1]), .st_m(st_m_s[1]), .st_ack(st_ack_s[1]));

  conv_tile_sched #(.N(5), .M(9), .TN(2), .TM(8), .CH_W(8), .DRAIN(DR)) u2 (
    .clk(clk), .reset_n(reset_n_s[2]), .start(start_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .ld_req(ld_req_s[2]), .ld_n(ld_n_s[2]), .ld_m(ld_m_s[2]), .ld_bias(ld_bias_s[2]),
    .ld_ack(ld_ack_s[2]), .conv_enable(conv_enable_s[2]), .conv_n(conv_n_s[2]),
    .conv_done(conv_done_s[2]), .st_req(st_req_s[2]), .st_m(st_m_s[2]), .st_ack(st_ack_s[2]));

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Loop nest straight from the tiling rules: m outer, n inner, store per m.
  task automatic build_model(input int k);
    n_ld[k] = 0;
    n_cv[k] = 0;
    n_st[k] = 0;
    for (int mm = 0; mm < cfg_m[k]; mm += 8) begin
      for (int nn = 0; nn < cfg_n[k]; nn += 2) begin
        e_ld_n[k][n_ld[k]] = nn;
        e_ld_m[k][n_ld[k]] = mm;
        e_ld_b[k][n_ld[k]] = (nn == 0) ? 1 : 0;
        n_ld[k]++;
        e_cv[k][n_cv[k]] = nn;
        n_cv[k]++;
      end
      e_st[k][n_st[k]] = mm;
      n_st[k]++;
    end
  endtask

  task automatic clear_mon(input int k);
    p_ld[k] = 0; p_cv[k] = 0; p_st[k] = 0;
    seen_done[k] = 0; layer_done[k] = 0;
    cd_pend[k] = 0; last_conv[k] = 0;
    prev_ld[k] = 0; prev_st[k] = 0; prev_ce[k] = 0;
    prev_ldacc[k] = 0; prev_stacc[k] = 0;
  endtask

  task automatic chk_zero(input int k);
    chk("rst_busy",    int'(busy_s[k]), 0);
    chk("rst_done",    int'(done_s[k]), 0);
    chk("rst_ld_req",  int'(ld_req_s[k]), 0);
    chk("rst_ld_bias", int'(ld_bias_s[k]), 0);
    chk("rst_conv_en", int'(conv_enable_s[k]), 0);
    chk("rst_st_req",  int'(st_req_s[k]), 0);
    chk("rst_ld_n",    int'(ld_n_s[k]), 0);
    chk("rst_ld_m",    int'(ld_m_s[k]), 0);
    chk("rst_conv_n",  int'(conv_n_s[k]), 0);
    chk("rst_st_m",    int'(st_m_s[k]), 0);
  endtask

  // Loader/store/conv-engine stand-in, optionally injecting stray pulses.
  task automatic responder(input int k);
    int la = -1;
    int sa = -1;
    int ca = -1;
    bit stray_start = 0;
    forever begin
      @(posedge clk);
      #1;
      ld_ack_s[k]    = 1'b0;
      st_ack_s[k]    = 1'b0;
      conv_done_s[k] = 1'b0;
      if (stray_start) begin
        start_s[k]  = 1'b0;
        stray_start = 0;
      end
      if (!reset_n_s[k]) begin
        la = -1; sa = -1; ca = -1;
      end else begin
        la = ld_req_s[k] ? la + 1 : -1;
        sa = st_req_s[k] ? sa + 1 : -1;
        if (conv_enable_s[k]) ca = 0;
        else if (ca >= 0) ca++;
        if (la == ack_dly[k]) begin
          ld_ack_s[k] = 1'b1;
          lack_cyc[k] = cyc;
        end
        if (sa == ack_dly[k]) st_ack_s[k] = 1'b1;
        if (ca == 10) begin
          conv_done_s[k] = 1'b1;
          cd_cyc[k]  = cyc;
          cd_pend[k] = 1;
          ca = -1;
        end
        if (noise[k]) begin
          if (la == 1 || sa == 1) conv_done_s[k] = 1'b1;
          if (ca == 3) begin
            st_ack_s[k] = 1'b1;
            start_s[k]  = 1'b1;
            stray_start = 1;
          end
          if (ca == 5) ld_ack_s[k] = 1'b1;
        end
      end
    end
  endtask

  initial fork
    responder(0);
    responder(1);
    responder(2);
  join_none

  task automatic mon(input int k);
    if (active[k] && reset_n_s[k]) begin
      if (ld_req_s[k] && !prev_ld[k]) begin
        if (p_ld[k] < n_ld[k]) begin
          chk("ld_n",    int'(ld_n_s[k]),    e_ld_n[k][p_ld[k]]);
          chk("ld_m",    int'(ld_m_s[k]),    e_ld_m[k][p_ld[k]]);
          chk("ld_bias", int'(ld_bias_s[k]), e_ld_b[k][p_ld[k]]);
        end else chk("ld_count", p_ld[k] + 1, n_ld[k]);
        p_ld[k]++;
        if (cd_pend[k]) begin
          chk("drain_gap_ld", cyc - cd_cyc[k], DR + 1);
          chk("conv_n_hold", int'(conv_n_s[k]), last_conv[k]);
          cd_pend[k] = 0;
        end
      end
      if (st_req_s[k] && !prev_st[k]) begin
        if (p_st[k] < n_st[k]) chk("st_m", int'(st_m_s[k]), e_st[k][p_st[k]]);
        else chk("st_count", p_st[k] + 1, n_st[k]);
        p_st[k]++;
        if (cd_pend[k]) begin
          chk("drain_gap_st", cyc - cd_cyc[k], DR + 1);
          chk("conv_n_hold", int'(conv_n_s[k]), last_conv[k]);
          cd_pend[k] = 0;
        end
      end
      if (conv_enable_s[k]) begin
        if (p_cv[k] < n_cv[k]) begin
          chk("conv_n", int'(conv_n_s[k]), e_cv[k][p_cv[k]]);
          last_conv[k] = e_cv[k][p_cv[k]];
        end else chk("conv_count", p_cv[k] + 1, n_cv[k]);
        chk("ack_to_enable", cyc - lack_cyc[k], 2);
        p_cv[k]++;
      end
      if (prev_ce[k])    chk("enable_pulse", int'(conv_enable_s[k]), 0);
      if (prev_ldacc[k]) chk("ld_req_drop",  int'(ld_req_s[k]), 0);
      if (prev_stacc[k]) chk("st_req_drop",  int'(st_req_s[k]), 0);
      if (cyc == start_cyc[k]) chk("busy_before_accept", int'(busy_s[k]), 0);
      else if (cyc > start_cyc[k]) begin
        if (done_s[k]) begin
          seen_done[k]++;
          chk("busy_in_done", int'(busy_s[k]), 0);
          layer_done[k] = 1;
        end else chk("busy", int'(busy_s[k]), layer_done[k] ? 0 : 1);
      end
      prev_ld[k]    = ld_req_s[k];
      prev_st[k]    = st_req_s[k];
      prev_ce[k]    = conv_enable_s[k];
      prev_ldacc[k] = ld_req_s[k] && ld_ack_s[k];
      prev_stacc[k] = st_req_s[k] && st_ack_s[k];
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < NI; k++) mon(k);
  end

  task automatic launch(input int k, input int dly, input bit nz);
    build_model(k);
    clear_mon(k);
    ack_dly[k] = dly;
    noise[k]   = nz;
    @(posedge clk);
    #2;
    start_cyc[k] = cyc;
    active[k]    = 1;
    start_s[k]   = 1'b1;
    @(posedge clk);
    #2;
    start_s[k] = 1'b0;
  endtask

  task automatic run_layer(input int k, input int dly, input bit nz);
    int g = 0;
    launch(k, dly, nz);
    while (!layer_done[k] && g < 3000) begin
      @(posedge clk);
      g++;
    end
    chk("done_timeout", int'(layer_done[k]), 1);
    repeat (6) @(posedge clk);
    active[k] = 0;
    chk("loads",  p_ld[k], n_ld[k]);
    chk("convs",  p_cv[k], n_cv[k]);
    chk("stores", p_st[k], n_st[k]);
    chk("done_pulses", seen_done[k], 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    for (int k = 0; k < NI; k++) begin
      reset_n_s[k] = 1'b0; start_s[k] = 1'b0; ld_ack_s[k] = 1'b0;
      conv_done_s[k] = 1'b0; st_ack_s[k] = 1'b0; active[k] = 0;
      ack_dly[k] = 2; noise[k] = 0; start_cyc[k] = 0; lack_cyc[k] = 0; cd_cyc[k] = 0;
    end
    repeat (3) @(posedge clk);
    #3;
    for (int k = 0; k < NI; k++) chk_zero(k);
    for (int k = 0; k < NI; k++) reset_n_s[k] = 1'b1;
    repeat (2) @(posedge clk);

    // Model pins for N=3, M=16.
    build_model(0);
    chk("model0_loads", n_ld[0], 4);
    chk("model0_ld1_n", e_ld_n[0][1], 2);
    chk("model0_ld2_m", e_ld_m[0][2], 8);
    chk("model0_ld2_b", e_ld_b[0][2], 1);
    chk("model0_ld3_b", e_ld_b[0][3], 0);
    chk("model0_st1",   e_st[0][1], 8);

    run_layer(0, 2, 0);
    run_layer(0, 2, 1);

    build_model(1);
    chk("model1_loads", n_ld[1], 1);
    chk("model1_stores", n_st[1], 1);
    run_layer(1, 0, 0);

    // Reset three cycles into WAIT of the second pass.
    g = 0;
    launch(0, 2, 0);
    while (p_cv[0] < 2 && g < 500) begin
      @(posedge clk);
      g++;
    end
    chk("reach_second_pass", p_cv[0], 2);
    repeat (2) @(posedge clk);
    #3;
    chk("no_done_before_reset", seen_done[0], 0);
    active[0] = 0;
    reset_n_s[0] = 1'b0;
    #1;
    chk_zero(0);
    repeat (3) begin
      @(posedge clk);
      #3;
      chk("done_in_reset", int'(done_s[0]), 0);
    end
    reset_n_s[0] = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("idle_after_reset_busy", int'(busy_s[0]), 0);
    chk("idle_after_reset_req", int'(ld_req_s[0]), 0);
    run_layer(0, 2, 0);

    // Model pins for N=5, M=9.
    build_model(2);
    chk("model2_convs", n_cv[2], 6);
    chk("model2_cv2", e_cv[2][2], 4);
    chk("model2_cv5", e_cv[2][5], 4);
    chk("model2_st1", e_st[2][1], 8);
    run_layer(2, 2, 0);
    chk("layer2_conv_passes", p_cv[2], 6);
    chk("layer2_stores", p_st[2], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
